// File: rtl/tc_boot_copier.sv
// ============================================================================
// Module   : tc_boot_copier
// Brief    : Boot sequencer. Reads the image length from the file loader,
//            copies the image 64 bits at a time into destination memory and
//            releases the CPU reset once the copy is complete.
//            Optional macro TC_BOOT_COPIER_CHECKSUM_EN adds a 32-bit byte-sum
//            output over every committed byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_boot_copier #(
    parameter logic [63:0] MAX_BYTES = 64'd1048576,
    parameter logic [63:0] DEST_BASE = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        src_en,
    output logic [63:0] src_addr,
    input  logic [63:0] src_data,
    output logic        mem_wr_valid,
    input  logic        mem_wr_ready,
    output logic [63:0] mem_wr_addr,
    output logic [63:0] mem_wr_data,
    output logic        busy,
    output logic        done,
    output logic        cpu_rst,
`ifdef TC_BOOT_COPIER_CHECKSUM_EN
    output logic [31:0] checksum,
`endif
    output logic [63:0] bytes_copied
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SIZE  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [63:0] c_size_addr = '1;

    state_t      r_state;
    logic [63:0] r_offset;
    logic [63:0] r_len;

    logic [63:0] w_remain;
    logic        w_last;
    logic [63:0] w_step;
    logic [63:0] w_clamped_len;
    logic [63:0] w_masked_data;
    logic [31:0] w_word_sum;

    // Bytes still owed; offset never exceeds len while READ/WRITE are active.
    assign w_remain      = r_len - r_offset;
    assign w_last        = (w_remain <= 64'd8);
    assign w_step        = w_last ? w_remain : 64'd8;
    assign w_clamped_len = (src_data > MAX_BYTES) ? MAX_BYTES : src_data;

    // Lanes past the end of the image are zeroed so trailing garbage never lands.
    always_comb begin
        w_masked_data = '0;
        for (int k = 0; k < 8; k++) begin
            if (w_remain > 64'(k)) begin
                w_masked_data[k*8 +: 8] = src_data[k*8 +: 8];
            end
        end
    end

    always_comb begin
        w_word_sum = '0;
        for (int k = 0; k < 8; k++) begin
            w_word_sum = w_word_sum + {24'd0, mem_wr_data[k*8 +: 8]};
        end
    end

    // Source port decodes straight from state so the read data is usable this cycle.
    always_comb begin
        src_en   = 1'b0;
        src_addr = '0;
        case (r_state)
            S_SIZE: begin
                src_en   = 1'b1;
                src_addr = c_size_addr;
            end
            S_READ: begin
                src_en   = 1'b1;
                src_addr = r_offset;
            end
            default: begin
                src_en   = 1'b0;
                src_addr = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_offset     <= '0;
            r_len        <= '0;
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cpu_rst      <= 1'b1;
            bytes_copied <= '0;
`ifdef TC_BOOT_COPIER_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SIZE;
                        busy    <= 1'b1;
                    end
                end
                S_SIZE: begin
                    r_len    <= w_clamped_len;
                    r_offset <= '0;
                    if (w_clamped_len == 64'd0) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    mem_wr_data  <= w_masked_data;
                    mem_wr_addr  <= DEST_BASE + r_offset;
                    mem_wr_valid <= 1'b1;
                    r_state      <= S_WRITE;
                end
                S_WRITE: begin
                    if (mem_wr_ready) begin
                        mem_wr_valid <= 1'b0;
                        bytes_copied <= bytes_copied + w_step;
                        r_offset     <= r_offset + 64'd8;
`ifdef TC_BOOT_COPIER_CHECKSUM_EN
                        checksum     <= checksum + w_word_sum;
`endif
                        if (w_last) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef TC_BOOT_COPIER_CHECKSUM_EN
    logic w_unused_sum;
    assign w_unused_sum = ^w_word_sum;
`endif

endmodule

`default_nettype wire

// File: doc/tc_boot_copier.md
Name: tc_boot_copier

Overview:
- Boot sequencer for the file-loader datapath (combinational byte-addressed source: en, 64-bit address, 64-bit little-endian read; address all-ones returns the file length).
- Reads the file length, then copies the image 64 bits at a time into a destination memory through a valid/ready write port.
- Holds the CPU in reset until the copy completes, then releases it.

Parameters:
- MAX_BYTES, 1048576, hard cap on bytes copied; the length read from the source is clamped to this value.
- DEST_BASE, 0, destination byte address of the first word written.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin copy; sampled only in IDLE.
- src_en  out  1  source enable.
- src_addr  out  64  source byte address.
- src_data  in  64  source read data, valid in the same cycle as src_addr.
- mem_wr_valid  out  1  destination write request.
- mem_wr_ready  in  1  destination accepts the write.
- mem_wr_addr  out  64  destination byte address.
- mem_wr_data  out  64  destination write data.
- busy  out  1  high in SIZE, READ and WRITE.
- done  out  1  copy complete; sticky until rst.
- cpu_rst  out  1  CPU reset; high from reset until DONE.
- bytes_copied  out  64  running count of bytes committed (clamped length at DONE).

Behaviour:
- Reset values:
  - state = IDLE.
  - src_en, mem_wr_valid, busy, done = 0.
  - src_addr, mem_wr_addr, mem_wr_data, bytes_copied, internal offset and length = 0.
  - cpu_rst = 1.
- Reset wins over every other event, including mid-WRITE; a pending write is dropped.
- States: IDLE, SIZE, READ, WRITE, DONE. Outputs are registered except src_en and src_addr, which decode from state.
- IDLE:
  - src_en = 0, src_addr = 0.
  - start = 1 → SIZE.
- SIZE (1 cycle):
  - src_en = 1, src_addr = all-ones.
  - At the edge, len = min(src_data, MAX_BYTES) and offset = 0.
  - len == 0 → DONE; otherwise → READ.
- READ (1 cycle):
  - src_en = 1, src_addr = offset.
  - At the edge, mem_wr_data captures src_data with byte lanes k where offset+k ≥ len forced to 0.
  - mem_wr_addr = DEST_BASE + offset, mem_wr_valid = 1 → WRITE.
- WRITE:
  - src_en = 0.
  - mem_wr_valid, mem_wr_addr and mem_wr_data are held stable until mem_wr_ready = 1.
  - On handshake: bytes_copied += min(8, len − offset), offset += 8, mem_wr_valid = 0.
  - offset + 8 ≥ len → DONE; otherwise → READ.
- DONE:
  - done = 1 and cpu_rst = 0, both asserted in the same cycle; busy = 0.
  - start is ignored. Exit only via rst.
- Timing:
  - Minimum 2 cycles per word.
  - With start sampled at edge e0, the first mem_wr_valid is high in the cycle after edge e2.
- Arithmetic:
  - offset, len and the address sum are 64-bit unsigned; wrap of DEST_BASE + offset is not checked.
  - The final word is partial when len mod 8 ≠ 0.
- mem_wr_ready while mem_wr_valid = 0 is ignored.

Optional Feature:
- Macro: TC_BOOT_COPIER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (out, 32): wrapping 32-bit sum of every byte committed (masked bytes excluded).
  - Updated on each handshake; reset to 0 by rst.
  - Stable once done = 1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Source of 20 bytes 0x01..0x14, ready = 1, start pulse:
  - Writes at DEST_BASE, +8, +16.
  - Data 0x0807060504030201, 0x100F0E0D0C0B0A09, 0x0000000014131211.
  - done = 1 and cpu_rst = 0 in the same cycle; bytes_copied = 20.
  - With the macro defined: checksum = 210.
- Backpressure: hold ready = 0 for 5 cycles on the second write → valid stays 1, address and data unchanged, no extra source reads, completion delayed by 5 cycles.
- Length 0 → no mem_wr_valid; done = 1 two cycles after start is sampled; bytes_copied = 0.
- MAX_BYTES = 16, file length 100 → exactly 2 writes; bytes_copied = 16.
- Assert rst during WRITE → next cycle all outputs at reset values and cpu_rst = 1; a new start repeats the copy correctly.
- start re-pulsed while busy and while in DONE → no effect on the sequence or the outputs.
